// File: rtl/booth_seq_divider.sv
// Sequential restoring divider: one quotient bit per clock on operand magnitudes,
// with a sign fix-up cycle and start/busy/done handshake.
module booth_seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH-1:0] quo_work;
    logic [WIDTH-1:0] dvs_mag;
    logic             sign_q;
    logic             sign_r;
    logic             dbz;
    logic             ovf;

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign neg_a   = signed_mode & dividend[WIDTH-1];
    assign neg_b   = signed_mode & divisor[WIDTH-1];
    assign mag_a   = neg_a ? -dividend : dividend;
    assign mag_b   = neg_b ? -divisor : divisor;
    assign shifted = {part_rem[WIDTH-1:0], quo_work[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_mag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            part_rem    <= '0;
            quo_work    <= '0;
            dvs_mag     <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dbz         <= 1'b0;
            ovf         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        // On divide-by-zero the work register keeps the raw dividend for the remainder.
                        quo_work <= (divisor == '0) ? dividend : mag_a;
                        dvs_mag  <= mag_b;
                        sign_q   <= neg_a ^ neg_b;
                        sign_r   <= neg_a;
                        count    <= CW'(WIDTH);
                        part_rem <= '0;
                        dbz      <= (divisor == '0);
                        ovf      <= signed_mode && (dividend == MOST_NEG) && (divisor == '1);
                        state    <= (divisor == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    busy <= 1'b1;
                    if (trial[WIDTH]) begin
                        part_rem <= shifted;
                        quo_work <= {quo_work[WIDTH-2:0], 1'b0};
                    end else begin
                        part_rem <= trial;
                        quo_work <= {quo_work[WIDTH-2:0], 1'b1};
                    end
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= dbz;
                    overflow    <= ovf;
                    if (dbz) begin
                        quotient  <= '1;
                        remainder <= quo_work;
                    end else begin
                        quotient  <= sign_q ? -quo_work : quo_work;
                        remainder <= sign_r ? -part_rem[WIDTH-1:0] : part_rem[WIDTH-1:0];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_seq_divider.sv
// Self-checking bench: directed literal cases plus randomized operations compared
// cycle by cycle against an arithmetic reference model.
module tb_booth_seq_divider;
    localparam int W = 8;

    logic         clk         = 1'b0;
    logic         rst_n       = 1'b0;
    logic         start       = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] dividend    = '0;
    logic [W-1:0] divisor     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_mode(signed_mode),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    // Reference result packed as {quotient, remainder, div_by_zero, overflow}.
    function automatic logic [2*W+1:0] ref_div(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           sa;
        int           sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (sm) begin
            sa = $signed(a);
            sb = $signed(b);
            if (sa == -(2 ** (W - 1)) && sb == -1) begin
                q  = {1'b1, {(W-1){1'b0}}};
                r  = '0;
                ov = 1'b1;
            end else begin
                q = W'(sa / sb);
                r = W'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r, dz, ov};
    endfunction

    logic             m_active = 1'b0;
    logic             m_busy   = 1'b0;
    logic             m_done   = 1'b0;
    logic             m_dz     = 1'b0;
    logic             m_ov     = 1'b0;
    logic [W-1:0]     m_q      = '0;
    logic [W-1:0]     m_r      = '0;
    logic [2*W+1:0]   m_pend   = '0;
    int               m_k      = 0;
    int               m_lat    = 0;

    // Timing model: done appears m_lat edges after acceptance, busy in between.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_dz     <= 1'b0;
            m_ov     <= 1'b0;
            m_q      <= '0;
            m_r      <= '0;
            m_pend   <= '0;
            m_k      <= 0;
            m_lat    <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (m_k + 1 == m_lat) begin
                    m_active <= 1'b0;
                    m_busy   <= 1'b0;
                    m_done   <= 1'b1;
                    {m_q, m_r, m_dz, m_ov} <= m_pend;
                end else begin
                    m_busy <= 1'b1;
                end
                m_k <= m_k + 1;
            end else begin
                m_busy <= 1'b0;
                if (start) begin
                    m_active <= 1'b1;
                    m_k      <= 0;
                    m_lat    <= (divisor == '0) ? 1 : W + 1;
                    m_pend   <= ref_div(signed_mode, dividend, divisor);
                end
            end
        end
    end

    always @(negedge clk) begin
        total++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !==
            {m_busy, m_done, m_q, m_r, m_dz, m_ov}) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t got busy=%b done=%b q=%h r=%h dz=%b ov=%b want busy=%b done=%b q=%h r=%h dz=%b ov=%b",
                     $time, busy, done, quotient, remainder, div_by_zero, overflow,
                     m_busy, m_done, m_q, m_r, m_dz, m_ov);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, exp);
        end
    endtask

    // Called at a negedge; drives start this cycle and returns at the negedge of the done cycle.
    task automatic do_op(input string tag, input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke, input logic [2*W+1:0] exp, input int elat, input int ebusy);
        int n;
        int bc;
        start       = 1'b1;
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        bc    = 0;
        while (!done && n < 40) begin
            bc += int'(busy);
            dividend    = W'($urandom);
            divisor     = W'($urandom);
            signed_mode = 1'($urandom_range(0, 1));
            start       = poke && (n == 2);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        $display("txn %s sm=%0d %h/%h -> q=%h r=%h dz=%b ov=%b lat=%0d busy=%0d",
                 tag, sm, a, b, quotient, remainder, div_by_zero, overflow, n, bc);
        chk({tag, "_lat"}, n, elat);
        chk({tag, "_q"}, {24'd0, quotient}, {24'd0, exp[2*W+1:W+2]});
        chk({tag, "_r"}, {24'd0, remainder}, {24'd0, exp[W+1:2]});
        chk({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, exp[1]});
        chk({tag, "_ov"}, {31'd0, overflow}, {31'd0, exp[0]});
        if (ebusy >= 0) chk({tag, "_busy_cycles"}, bc, ebusy);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners [6];
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'hFE};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return W'($urandom);
    endfunction

    initial begin
        logic         sm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           dc;

        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_q", {24'd0, quotient}, 32'd0);
        chk("reset_r", {24'd0, remainder}, 32'd0);
        rst_n = 1'b1;

        @(negedge clk); do_op("s100_7",    1'b1, 8'h64, 8'h07, 1'b0, {8'h0E, 8'h02, 2'b00}, 9, 8);
        @(negedge clk); do_op("sm100_7",   1'b1, 8'h9C, 8'h07, 1'b0, {8'hF2, 8'hFE, 2'b00}, 9, 8);
        @(negedge clk); do_op("s100_m7",   1'b1, 8'h64, 8'hF9, 1'b0, {8'hF2, 8'h02, 2'b00}, 9, 8);
        @(negedge clk); do_op("uFF_10",    1'b0, 8'hFF, 8'h10, 1'b0, {8'h0F, 8'h0F, 2'b00}, 9, 8);
        @(negedge clk); do_op("sFF_10",    1'b1, 8'hFF, 8'h10, 1'b0, {8'h00, 8'hFF, 2'b00}, 9, 8);
        @(negedge clk); do_op("dbz",       1'b1, 8'h05, 8'h00, 1'b0, {8'hFF, 8'h05, 2'b10}, 1, 0);
        @(negedge clk); do_op("ovf",       1'b1, 8'h80, 8'hFF, 1'b0, {8'h80, 8'h00, 2'b01}, 9, 8);
        @(negedge clk); do_op("min_1",     1'b1, 8'h80, 8'h01, 1'b0, {8'h80, 8'h00, 2'b00}, 9, 8);
        @(negedge clk); do_op("poke",      1'b1, 8'h64, 8'h07, 1'b1, {8'h0E, 8'h02, 2'b00}, 9, 8);
        @(negedge clk); do_op("b2b_first", 1'b0, 8'hC8, 8'h0A, 1'b0, {8'h14, 8'h00, 2'b00}, 9, 8);
        do_op("b2b_second", 1'b1, 8'hF6, 8'h03, 1'b0, {8'hFD, 8'hFF, 2'b00}, 9, 8);

        // Abort an operation with reset after its fourth edge.
        @(negedge clk);
        start       = 1'b1;
        signed_mode = 1'b1;
        dividend    = 8'h64;
        divisor     = 8'h07;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_q", {24'd0, quotient}, 32'd0);
        chk("abort_r", {24'd0, remainder}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        repeat (15) begin
            @(negedge clk);
            dc += int'(done);
        end
        chk("abort_no_done", dc, 0);

        for (int i = 0; i < 120; i++) begin
            sm = 1'($urandom_range(0, 1));
            a  = pick();
            b  = ($urandom_range(0, 9) == 0) ? 8'h00 : pick();
            if ($urandom_range(0, 3) != 0) @(negedge clk);
            do_op("rnd", sm, a, b, ($urandom_range(0, 4) == 0), ref_div(sm, a, b), (b == 8'h00) ? 1 : 9, -1);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
